vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_arbiter.sv | 120 ++++++++++++
 tb/tb_vram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM types and sizing.
// Used by the arbiter, the text-controller AXI slave and the draw logic.
package vram_pkg;

    // Owner of the single RAM port in a given cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        HOST = 2'd2
    } owner_t;

    localparam int VRAM_DEPTH = 1200;
    localparam int ADDR_W     = 11;

endpackage

// File: rtl/vram_arbiter.sv
// Host/video arbiter for a single-port VRAM with 1-cycle read latency.
// Ports: axi_aclk/axi_aresetn; host_* (rd/wr, strobes) and vid_*
// (read-only) request/grant/rvalid channels; ram_* drive the external RAM.
module vram_arbiter #(
    parameter int ADDR_W       = vram_pkg::ADDR_W,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = vram_pkg::VRAM_DEPTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                axi_aclk,
    input  logic                axi_aresetn,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    input  logic [DATA_W/8-1:0] host_wstrb,
    output logic                host_gnt,
    output logic                host_rvalid,
    output logic [DATA_W-1:0]   host_rdata,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic                vid_gnt,
    output logic                vid_rvalid,
    output logic [DATA_W-1:0]   vid_rdata,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    import vram_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    owner_t             owner;
    owner_t             owner_nxt;
    logic [CNT_W-1:0]   starve_cnt;
    logic               rd_pend;
    logic               rd_oob;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_wdata;
    logic               cur_we;
    logic               cur_read;
    logic               in_range;

    // Video wins ties until the host has watched STARVE_LIMIT video
    // grants go by; grants are forced off while in reset.
    always_comb begin
        owner_nxt = IDLE;
        if (axi_aresetn) begin
            if (host_req && (!vid_req || starve_cnt == CNT_MAX))
                owner_nxt = HOST;
            else if (vid_req)
                owner_nxt = VID;
        end
    end

    assign host_gnt = (owner_nxt == HOST);
    assign vid_gnt  = (owner_nxt == VID);

    // Port mux; with no grant the address/data buses hold their last value.
    always_comb begin
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_we    = 1'b0;
        cur_read  = 1'b0;
        unique case (owner_nxt)
            HOST: begin
                cur_addr  = host_addr;
                cur_wdata = host_wdata;
                cur_we    = host_we;
                cur_read  = !host_we;
            end
            VID: begin
                cur_addr = vid_addr;
                cur_read = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_range  = (32'(cur_addr) < 32'(DEPTH));
    assign ram_en    = (owner_nxt != IDLE) && in_range;
    assign ram_we    = (cur_we && in_range) ? host_wstrb : '0;
    assign ram_addr  = cur_addr;
    assign ram_wdata = cur_wdata;

    // owner doubles as the read-return tag: it names last cycle's grantee.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            owner      <= IDLE;
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_oob     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            owner   <= owner_nxt;
            rd_pend <= cur_read;
            rd_oob  <= !in_range;
            addr_q  <= cur_addr;
            wdata_q <= cur_wdata;
            if (!host_req || host_gnt)
                starve_cnt <= '0;
            else if (vid_gnt && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign host_rvalid = rd_pend && (owner == HOST);
    assign vid_rvalid  = rd_pend && (owner == VID);
    assign host_rdata  = (host_rvalid && !rd_oob) ? ram_rdata : '0;
    assign vid_rdata   = (vid_rvalid && !rd_oob) ? ram_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural 1-cycle RAM.
// Stimulus pushes expected read data; a negedge monitor pops and compares.
module tb_vram_arbiter;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [10:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic [3:0]  host_wstrb = '0;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        vid_req = 1'b0;
    logic [10:0] vid_addr = '0;
    logic        vid_gnt;
    logic        vid_rvalid;
    logic [31:0] vid_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem [0:2047];

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t hq[$];
    exp_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    vram_arbiter dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_wstrb  (host_wstrb),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_gnt     (vid_gnt),
        .vid_rvalid  (vid_rvalid),
        .vid_rdata   (vid_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 axi_aclk = ~axi_aclk;

    always @(posedge axi_aclk) cyc <= cyc + 1;

    // External single-port RAM, byte-writable, 1-cycle read latency.
    always @(posedge axi_aclk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b])
                    mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever an rvalid shows up.
    always @(negedge axi_aclk) begin
        exp_t e;
        chk("one_grant", 32'(host_gnt & vid_gnt), 32'd0);

        while (hq.size() > 0 && hq[0].cyc + 1 < cyc) begin
            checks++;
            errors++;
            $display("FAIL host_rvalid_missing: none for grant at cycle %0d",
                     hq[0].cyc);
            void'(hq.pop_front());
        end
        if (host_rvalid) begin
            if (hq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL host_rvalid_spurious: got %h want no rvalid",
                         host_rdata);
            end else begin
                e = hq.pop_front();
                chk("host_rvalid_latency", 32'(cyc), 32'(e.cyc + 1));
                chk("host_rdata", host_rdata, e.data);
            end
        end else begin
            chk("host_rdata_idle", host_rdata, 32'd0);
        end

        while (vq.size() > 0 && vq[0].cyc + 1 < cyc) begin
            checks++;
            errors++;
            $display("FAIL vid_rvalid_missing: none for grant at cycle %0d",
                     vq[0].cyc);
            void'(vq.pop_front());
        end
        if (vid_rvalid) begin
            if (vq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vid_rvalid_spurious: got %h want no rvalid",
                         vid_rdata);
            end else begin
                e = vq.pop_front();
                chk("vid_rvalid_latency", 32'(cyc), 32'(e.cyc + 1));
                chk("vid_rdata", vid_rdata, e.data);
            end
        end else begin
            chk("vid_rdata_idle", vid_rdata, 32'd0);
        end
    end

    function automatic logic [31:0] expval(input int a);
        case (a)
            5:       return 32'hDEADBEEF;
            7:       return 32'h1122AB44;
            default: return 32'hA5A50000 | 32'(a);
        endcase
    endfunction

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic idle();
        host_req = 1'b0;
        vid_req  = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_host_gnt"}, 32'(host_gnt), 32'd0);
        chk({tag, "_vid_gnt"}, 32'(vid_gnt), 32'd0);
        chk({tag, "_host_rvalid"}, 32'(host_rvalid), 32'd0);
        chk({tag, "_vid_rvalid"}, 32'(vid_rvalid), 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    endtask

    task automatic host_op(input logic we, input logic [10:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [3:0] exp_we, input logic exp_en,
                           input logic [31:0] exp_rd);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        host_wstrb = s;
        @(negedge axi_aclk);
        chk("host_gnt", 32'(host_gnt), 32'd1);
        chk("host_ram_we", 32'(ram_we), 32'(exp_we));
        chk("host_ram_en", 32'(ram_en), 32'(exp_en));
        if (!we) hq.push_back('{data: exp_rd, cyc: cyc});
        tick();
        host_req = 1'b0;
    endtask

    task automatic vid_op(input logic [10:0] a, input logic [31:0] exp_rd);
        vid_req  = 1'b1;
        vid_addr = a;
        @(negedge axi_aclk);
        chk("vid_gnt", 32'(vid_gnt), 32'd1);
        chk("vid_host_gnt", 32'(host_gnt), 32'd0);
        vq.push_back('{data: exp_rd, cyc: cyc});
        tick();
        vid_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Requests high during reset must not produce grants.
        host_req = 1'b1;
        vid_req  = 1'b1;
        repeat (2) begin
            @(negedge axi_aclk);
            all_zero("rst0");
        end
        @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        idle();

        // Write then read back, first grant right after release.
        host_op(1'b1, 11'd5, 32'hDEADBEEF, 4'hF, 4'hF, 1'b1, 32'h0);
        host_op(1'b0, 11'd5, 32'h0, 4'h0, 4'h0, 1'b1, 32'hDEADBEEF);

        // Partial strobe merge.
        host_op(1'b1, 11'd7, 32'h11223344, 4'hF, 4'hF, 1'b1, 32'h0);
        host_op(1'b1, 11'd7, 32'h0000AB00, 4'b0010, 4'b0010, 1'b1, 32'h0);
        host_op(1'b0, 11'd7, 32'h0, 4'h0, 4'h0, 1'b1, 32'h1122AB44);

        for (int i = 0; i < 10; i++)
            if (i != 5 && i != 7)
                host_op(1'b1, 11'(i), 32'hA5A50000 | 32'(i), 4'hF, 4'hF,
                        1'b1, 32'h0);

        // Starvation: both held; host wins on the 5th cycle only.
        host_we   = 1'b0;
        host_addr = 11'd5;
        vid_addr  = 11'd7;
        host_req  = 1'b1;
        vid_req   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge axi_aclk);
            if (i == 4) begin
                chk("starve_host_gnt", 32'(host_gnt), 32'd1);
                chk("starve_vid_gnt", 32'(vid_gnt), 32'd0);
                hq.push_back('{data: 32'hDEADBEEF, cyc: cyc});
            end else begin
                chk("starve_vid_gnt", 32'(vid_gnt), 32'd1);
                chk("starve_host_gnt", 32'(host_gnt), 32'd0);
                vq.push_back('{data: 32'h1122AB44, cyc: cyc});
            end
            tick();
        end
        idle();

        // Out-of-range accesses are granted but never touch the RAM.
        host_op(1'b1, 11'd1200, 32'hFFFFFFFF, 4'hF, 4'h0, 1'b0, 32'h0);
        host_op(1'b0, 11'd1500, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        host_op(1'b0, 11'd1200, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        host_op(1'b0, 11'd0, 32'h0, 4'h0, 4'h0, 1'b1, 32'hA5A50000);

        // Alternating owners, one access every cycle.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                vid_op(11'(i), expval(i));
            else
                host_op(1'b0, 11'(i), 32'h0, 4'h0, 4'h0, 1'b1, expval(i));
        end

        // Reset while a video read is in flight.
        vid_req  = 1'b1;
        vid_addr = 11'd3;
        @(negedge axi_aclk);
        chk("pre_rst_vid_gnt", 32'(vid_gnt), 32'd1);
        @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b0;
        host_req = 1'b1;
        repeat (2) begin
            @(negedge axi_aclk);
            all_zero("rst1");
            chk("rst1_host_rdata", host_rdata, 32'd0);
            chk("rst1_vid_rdata", vid_rdata, 32'd0);
        end
        @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        host_req = 1'b0;
        @(negedge axi_aclk);
        chk("post_rst_vid_gnt", 32'(vid_gnt), 32'd1);
        vq.push_back('{data: 32'hA5A50003, cyc: cyc});
        tick();
        idle();

        // No request: RAM disabled, address bus holds.
        @(negedge axi_aclk);
        chk("idle_ram_en", 32'(ram_en), 32'd0);
        chk("idle_ram_we", 32'(ram_we), 32'd0);
        chk("idle_ram_addr", 32'(ram_addr), 32'd3);

        repeat (3) @(negedge axi_aclk);
        chk("drain_host", 32'(hq.size()), 32'd0);
        chk("drain_vid", 32'(vq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
